dual_port_memory: RTL

//   Parametrised synchronous dual-port RAM backing the CPU's instruction (port A,

---
 rtl/dual_port_memory.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dual_port_memory.sv
// dual_port_memory
//   Synchronous dual-port RAM. Port A is read-only (instruction fetch).
//   Port B reads and writes with a byte mask (data bus).
//   Read latency is 1 or 2 cycles. Port B read-during-write behaviour is
//   selectable. A same-address A-read/B-write collision can bypass the new
//   word to port A.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset; clears outputs and pipeline,
//                  leaves array contents alone
//   a_enable       port A read request
//   a_address      port A word address
//   a_read_data    port A read data; holds between results
//   a_valid        a_read_data updated this cycle
//   b_enable       port B access request
//   b_write_enable port B write, qualified by b_enable
//   b_byte_enable  per-byte write mask, bit i -> bits [8i+7:8i]
//   b_address      port B word address
//   b_write_data   port B write data
//   b_read_data    port B read data; holds between results
//   b_valid        b_read_data updated this cycle
`timescale 1ns/1ps
module dual_port_memory #(
  parameter int    DATA_WIDTH       = 16,
  parameter int    ADDR_WIDTH       = 16,
  parameter int    READ_LATENCY     = 1,
  parameter int    PORTB_MODE       = 0,  // 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE
  parameter int    COLLISION_BYPASS = 1,
  parameter string INIT_FILE        = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_enable,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  output logic [DATA_WIDTH-1:0]   a_read_data,
  output logic                    a_valid,
  input  logic                    b_enable,
  input  logic                    b_write_enable,
  input  logic [DATA_WIDTH/8-1:0] b_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH-1:0]   b_write_data,
  output logic [DATA_WIDTH-1:0]   b_read_data,
  output logic                    b_valid
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if (DATA_WIDTH <= 0 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("dual_port_memory: DATA_WIDTH must be a positive multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("dual_port_memory: READ_LATENCY must be 1 or 2");
  end
  if (PORTB_MODE < 0 || PORTB_MODE > 2) begin : g_bad_mode
    $error("dual_port_memory: PORTB_MODE must be 0, 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Power-up contents: all zeros.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Stage 0: combinational array look-up and byte merge
  logic [DATA_WIDTH-1:0] a_word, b_word, b_merged, a_rd0, b_rd0;
  logic                  b_wr, collide, b_upd;

  always_comb begin
    a_word   = mem[a_address];
    b_word   = mem[b_address];
    b_merged = b_word;
    for (int i = 0; i < NUM_BYTES; i++)
      if (b_byte_enable[i]) b_merged[8*i +: 8] = b_write_data[8*i +: 8];
    // An all-zero mask changes nothing, so it is treated as a plain read.
    b_wr    = b_enable & b_write_enable & (|b_byte_enable);
    collide = a_enable & b_wr & (a_address == b_address);
    a_rd0   = (collide && COLLISION_BYPASS != 0) ? b_merged : a_word;
    // NO_CHANGE: a real write produces no port-B result at all.
    b_upd   = b_enable & ~(b_wr & (PORTB_MODE == 2));
    b_rd0   = (b_wr && PORTB_MODE == 0) ? b_merged : b_word;
  end

  // Writes are gated by reset so nothing lands while it is held low.
  always_ff @(posedge clock) begin
    if (reset && b_wr)
      for (int i = 0; i < NUM_BYTES; i++)
        if (b_byte_enable[i]) mem[b_address][8*i +: 8] <= b_write_data[8*i +: 8];
  end

  // Stage 1: data registers only load on a result, so they hold otherwise.
  logic [DATA_WIDTH-1:0] a_dat1, b_dat1;
  logic                  a_vld1, b_vld1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_dat1 <= '0;
      b_dat1 <= '0;
      a_vld1 <= 1'b0;
      b_vld1 <= 1'b0;
    end else begin
      a_vld1 <= a_enable;
      b_vld1 <= b_upd;
      if (a_enable) a_dat1 <= a_rd0;
      if (b_upd)    b_dat1 <= b_rd0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    // Stage 2: reset drops anything in flight; it is never replayed.
    logic [DATA_WIDTH-1:0] a_dat2, b_dat2;
    logic                  a_vld2, b_vld2;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        a_dat2 <= '0;
        b_dat2 <= '0;
        a_vld2 <= 1'b0;
        b_vld2 <= 1'b0;
      end else begin
        a_vld2 <= a_vld1;
        b_vld2 <= b_vld1;
        if (a_vld1) a_dat2 <= a_dat1;
        if (b_vld1) b_dat2 <= b_dat1;
      end
    end

    assign a_read_data = a_dat2;
    assign a_valid     = a_vld2;
    assign b_read_data = b_dat2;
    assign b_valid     = b_vld2;
  end else begin : g_lat1
    assign a_read_data = a_dat1;
    assign a_valid     = a_vld1;
    assign b_read_data = b_dat1;
    assign b_valid     = b_vld1;
  end

endmodule
